t05_sram_arbiter: RTL and testbench
===================================

// Module: t05_sram_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer owning the single wishbone SRAM master port for all team_05 compression stages
//  (hist, flv, htree, codebook, translation). Grants one requester a 1-4 word burst, issues one strobe per word,
//  tracks busy_o, returns per-beat read data and acks, and flags SRAM timeouts. Sits between the stages and the wishbone manager.
// PARAMETERS
//  NREQ          5   number of requesters (index = HIST0..TRANSLATION4)
//  MAX_BEATS     4   max words per burst (req_len is 2 bits: beats-1)
//  BUSY_TIMEOUT  15  cycles to wait for busy_o to rise before abort
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous, active-low reset
//  req        in   NREQ     burst request per requester; held until its done pulse
//  req_we     in   NREQ     1 = write burst, 0 = read burst
//  req_addr   in   NREQ*32  start byte address (word aligned)
//  req_len    in   NREQ*2   beats-1 (0..3)
//  req_wdata  in   NREQ*32  write word for the requester's current beat
//  grant_id   out  3        index of current owner (valid while busy)
//  arb_busy   out  1        burst in progress
//  beat_ack   out  NREQ     1-cycle pulse per completed beat to owner
//  rdata      out  32       read word, valid with beat_ack
//  done       out  NREQ     1-cycle pulse on owner's final beat (or abort)
//  err        out  1        1-cycle pulse on timeout abort
//  wr_en      out  1        SRAM write strobe
//  r_en       out  1        SRAM read strobe
//  select     out  4        byte select
//  addr       out  32       SRAM byte address
//  data_i     out  32       SRAM write data
//  data_o     in   32       SRAM read data
//  busy_o     in   1        SRAM busy
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, rr pointer 0, every output 0 (select=0, grant_id=0). Mid-burst reset drops burst; no strobe after.
//  - States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> (ISSUE | IDLE).
//  - IDLE: if any req, pick first requester at/after rr pointer (wrapping); latch id, we, addr, len; beat=0; -> ISSUE next edge.
//  - ISSUE (exactly 1 cycle): r_en or wr_en = 1, addr = base + 4*beat (mod 2^32), data_i = req_wdata[id], select=4'hF. -> WAIT_BUSY.
//  - WAIT_BUSY: strobes 0; busy_o=1 -> WAIT_DONE; timeout counter reaching BUSY_TIMEOUT -> err, done[id], -> IDLE.
//  - WAIT_DONE: on busy_o=0: rdata<=data_o (reads; writes hold last), beat_ack[id] pulse; if beat==len also done[id], rr ptr=(id+1)%NREQ, -> IDLE; else beat++, -> ISSUE.
//  - Latency (1 beat): req edge k -> strobe cycle k+1 -> ack >= k+3 depending on busy_o length.
//  - Grant held for whole burst; req drop mid-burst ignored; other reqs wait. req_wdata sampled only in ISSUE.
//  - Simultaneous reqs resolved purely by rr pointer; new grant possible the cycle after done (one IDLE cycle).
//  - addr, select, data_i hold between strobes; select=0 and arb_busy=0 in IDLE.
// STRUCTURE
//  - t05_sram_pkg: arb_state_t enum, requester index localparams (REQ_HIST..REQ_TRN), region bases
//    HIST_BASE=0, HTREE_BASE=1024, CODEBOOK_BASE=2048, WORD_BYTES=4.
//  - Sub-module t05_rr_arbiter: req + pointer -> one-hot grant + index (combinational), pointer register inside.
//  - Top: FSM, beat counter, timeout counter, address/data regs.
// TESTING (bench SRAM model: busy_o high 2 cycles, starting 1 cycle after strobe)
//  1 req[0] read, addr 0x400, len 0, model data 0xDEADBEEF -> one r_en at 0x400, rdata=0xDEADBEEF, beat_ack[0]+done[0] same cycle.
//  2 req[3] write, addr 0x800, len 3, wdata 0x11,0x22,0x33,0x44 -> 4 wr_en pulses at 0x800/804/808/80C with matching data_i, 4 acks, 1 done.
//  3 All 5 req same cycle, len 0 -> grants in order 0,1,2,3,4; then req[0]+req[4] with ptr=0 -> 0 then 4.
//  4 busy_o stuck 0 after strobe -> err+done[id] 15 cycles later, no further strobe, next requester granted.
//  5 rst low during WAIT_DONE of beat 2 -> all outputs 0 immediately; after release same request restarts at beat 0.
//  6 addr 0xFFFFFFFC, len 1 read -> strobes at 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/t05_sram_arbiter_pkg.sv
// Shared types and constants for the team_05 SRAM arbiter slice.
// Requester indices follow the compression pipeline order, HIST first.
package t05_sram_pkg;
  localparam int NREQ         = 5;
  localparam int MAX_BEATS    = 4;
  localparam int BUSY_TIMEOUT = 15;
  localparam int WORD_BYTES   = 4;

  localparam int REQ_HIST     = 0;
  localparam int REQ_FLV      = 1;
  localparam int REQ_HTREE    = 2;
  localparam int REQ_CODEBOOK = 3;
  localparam int REQ_TRN      = 4;

  localparam logic [31:0] HIST_BASE     = 32'd0;
  localparam logic [31:0] HTREE_BASE    = 32'd1024;
  localparam logic [31:0] CODEBOOK_BASE = 32'd2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;

  function automatic logic [NREQ-1:0] id2oh(input logic [2:0] id);
    return NREQ'(1) << id;
  endfunction
endpackage

// File: rtl/t05_sram_arbiter_if.sv
// Requester-side burst bus plus wishbone SRAM strobe bus of the arbiter.
// The master modport is the arbiter; slave is the stages/SRAM side.
interface t05_sram_arbiter_if;
  import t05_sram_pkg::*;

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*32-1:0]   req_addr;
  logic [NREQ*2-1:0]    req_len;
  logic [NREQ*32-1:0]   req_wdata;
  logic [2:0]           grant_id;
  logic                 arb_busy;
  logic [NREQ-1:0]      beat_ack;
  logic [31:0]          rdata;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic                 wr_en;
  logic                 r_en;
  logic [3:0]           select;
  logic [31:0]          addr;
  logic [31:0]          data_i;
  logic [31:0]          data_o;
  logic                 busy_o;

  modport master (
    input  req, req_we, req_addr, req_len, req_wdata, data_o, busy_o,
    output grant_id, arb_busy, beat_ack, rdata, done, err,
           wr_en, r_en, select, addr, data_i
  );

  modport slave (
    output req, req_we, req_addr, req_len, req_wdata, data_o, busy_o,
    input  grant_id, arb_busy, beat_ack, rdata, done, err,
           wr_en, r_en, select, addr, data_i
  );
endinterface

// File: rtl/t05_sram_arbiter_rr_arbiter.sv
// Round-robin pick: combinational grant of first request at/after the pointer.
// Pointer moves to owner+1 when the owner's burst ends.
module t05_rr_arbiter
  import t05_sram_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  input  logic [2:0]      upd_id,
  output logic [NREQ-1:0] gnt_oh,
  output logic [2:0]      gnt_idx,
  output logic            gnt_vld
);
  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    j       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && req[j]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = 3'(j);
        gnt_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = (upd_id == 3'(NREQ - 1)) ? 3'd0 : upd_id + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin SRAM burst sequencer: 1-4 word bursts, one strobe per word, busy timeout.
// Strobe one cycle after grant; requesters wait on req (held) until their done pulse.
module t05_sram_arbiter
  import t05_sram_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  t05_sram_arbiter_if.master  bus
);
  arb_state_t      state_q, state_d;
  logic [2:0]      id_q, id_d;
  logic            we_q, we_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      beat_q, beat_d;
  logic [3:0]      tmo_q, tmo_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      select_q, select_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;

  logic            upd;
  logic [NREQ-1:0] gnt_oh;
  logic [2:0]      gnt_idx;
  logic            gnt_vld;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [1:0]      sel_len;
  logic [31:0]     cur_wdata;
  logic [NREQ-1:0] id_oh;

  t05_rr_arbiter u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .upd     (upd),
    .upd_id  (id_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel_we   = |(bus.req_we & gnt_oh);
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | (gnt_oh[i] ? bus.req_addr[32*i +: 32] : 32'd0);
      sel_len  = sel_len  | (gnt_oh[i] ? bus.req_len[2*i +: 2]    : 2'd0);
    end
  end

  assign cur_wdata = bus.req_wdata[32*int'(id_q) +: 32];
  assign id_oh     = id2oh(id_q);

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    len_d    = len_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    select_d = select_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    upd      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (gnt_vld) begin
          id_d     = gnt_idx;
          we_d     = sel_we;
          len_d    = sel_len;
          beat_d   = '0;
          addr_d   = sel_addr;
          select_d = 4'hF;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        data_d  = cur_wdata;
        tmo_d   = 4'd1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // tmo counts cycles since the strobe; abort once it would reach the limit
        tmo_d = tmo_q + 4'd1;
        if (bus.busy_o) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_d == 4'(BUSY_TIMEOUT)) begin
          err_d    = 1'b1;
          done_d   = id_oh;
          upd      = 1'b1;
          select_d = 4'h0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.busy_o) begin
          ack_d = id_oh;
          if (!we_q) rdata_d = bus.data_o;
          if (beat_q == len_q) begin
            done_d   = id_oh;
            upd      = 1'b1;
            select_d = 4'h0;
            state_d  = ST_IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            addr_d  = addr_q + 32'(WORD_BYTES);
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      we_q     <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      select_q <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      select_q <= select_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.grant_id = id_q;
  assign bus.arb_busy = (state_q != ST_IDLE);
  assign bus.beat_ack = ack_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.wr_en    = (state_q == ST_ISSUE) && we_q;
  assign bus.r_en     = (state_q == ST_ISSUE) && !we_q;
  assign bus.select   = select_q;
  assign bus.addr     = addr_q;
  // Write data is taken live from the owner during the strobe cycle, then held.
  assign bus.data_i   = (state_q == ST_ISSUE) ? cur_wdata : data_q;
endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Scoreboard bench for t05_sram_arbiter with a 2-cycle-busy SRAM model.
module tb_t05_sram_arbiter;
  import t05_sram_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  id;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strb_t;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] done;
    logic            err;
    logic [31:0]     rdata;
    int              gap;
  } resp_t;

  localparam logic [31:0] STUCK_ADDR = 32'h0000_0F00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  t05_sram_arbiter_if bus ();
  t05_sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  strb_t       sq[$];
  resp_t       rq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_strobe_cyc = 0;
  int          wbeat[NREQ];
  logic [31:0] last_rd;
  logic [2:0]  bcnt;
  logic [31:0] rd_q;
  strb_t       m_e;
  resp_t       m_r;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return (a == 32'h0000_0400) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [31:0] wd(input int b);
    return 32'(b + 1) * 32'h11;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [127:0] outs();
    return 128'({bus.grant_id, bus.arb_busy, bus.beat_ack, bus.done, bus.err, bus.wr_en,
                 bus.r_en, bus.select, bus.addr, bus.data_i, bus.rdata});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SRAM model: busy high for two cycles starting the cycle after a strobe
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0;
      rd_q <= '0;
    end else if ((bus.wr_en || bus.r_en) && bus.addr != STUCK_ADDR) begin
      bcnt <= 3'd2;
      if (bus.r_en) rd_q <= mrd(bus.addr);
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 3'd1;
    end
  end
  assign bus.busy_o = (bcnt != 0);
  assign bus.data_o = rd_q;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.wr_en || bus.r_en) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", {bus.wr_en, bus.r_en}, 2'b00);
        end else begin
          m_e = sq.pop_front();
          chk("strobe_we", bus.wr_en, m_e.we);
          chk("strobe_ren", bus.r_en, !m_e.we);
          chk("strobe_addr", bus.addr, m_e.addr);
          chk("strobe_gid", bus.grant_id, m_e.id);
          chk("strobe_sel", bus.select, 4'hF);
          chk("strobe_busy", bus.arb_busy, 1'b1);
          if (m_e.we) chk("strobe_wdata", bus.data_i, m_e.wdata);
        end
        last_strobe_cyc <= cyc;
      end
      if ((|bus.beat_ack) || (|bus.done) || bus.err) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", {bus.beat_ack, bus.done, bus.err}, '0);
        end else begin
          m_r = rq.pop_front();
          chk("resp_ack", bus.beat_ack, m_r.ack);
          chk("resp_done", bus.done, m_r.done);
          chk("resp_err", bus.err, m_r.err);
          chk("resp_rdata", bus.rdata, m_r.rdata);
          if (m_r.gap != 0) chk("resp_gap", cyc - last_strobe_cyc, m_r.gap);
        end
      end
    end
  end

  task automatic exp_rd(input int id, input logic [31:0] a, input bit last, input int gap);
    sq.push_back('{we: 1'b0, id: 3'(id), addr: a, wdata: 32'd0});
    last_rd = mrd(a);
    rq.push_back('{ack: oh(id), done: last ? oh(id) : '0, err: 1'b0, rdata: last_rd, gap: gap});
  endtask

  task automatic exp_wr(input int id, input logic [31:0] a, input logic [31:0] d, input bit last);
    sq.push_back('{we: 1'b1, id: 3'(id), addr: a, wdata: d});
    rq.push_back('{ack: oh(id), done: last ? oh(id) : '0, err: 1'b0, rdata: last_rd, gap: 0});
  endtask

  task automatic start_req(input int id, input logic we, input logic [31:0] a, input int len);
    wbeat[id]                  = 0;
    bus.req_we[id]             = we;
    bus.req_addr[32*id +: 32]  = a;
    bus.req_len[2*id +: 2]     = 2'(len);
    bus.req_wdata[32*id +: 32] = wd(0);
    bus.req[id]                = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (bus.req != '0 && n < budget) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.beat_ack[i]) begin
          wbeat[i]++;
          bus.req_wdata[32*i +: 32] = wd(wbeat[i]);
        end
        if (bus.done[i]) bus.req[i] = 1'b0;
      end
      n++;
    end
    if (bus.req != '0) begin
      chk("burst_timeout", bus.req, '0);
      bus.req = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("strobes_left", sq.size(), 0);
    chk("resps_left", rq.size(), 0);
  endtask

  initial begin
    int n;
    int acks;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    last_rd       = '0;
    for (int i = 0; i < NREQ; i++) wbeat[i] = 0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), '0);
    @(negedge clk) rst = 1'b1;

    // all five at once, pointer 0: grants 0..4
    for (int i = 0; i < NREQ; i++) exp_rd(i, 32'h1000 + 32'(16 * i), 1'b1, 0);
    for (int i = 0; i < NREQ; i++) start_req(i, 1'b0, 32'h1000 + 32'(16 * i), 0);
    run_until_idle(300);

    // req 0 and 4 with pointer back at 0
    exp_rd(REQ_HIST, 32'h0000_0040, 1'b1, 0);
    exp_rd(REQ_TRN, 32'h0000_0044, 1'b1, 0);
    start_req(REQ_HIST, 1'b0, 32'h0000_0040, 0);
    start_req(REQ_TRN, 1'b0, 32'h0000_0044, 0);
    run_until_idle(200);

    // single-beat read, checks ack latency after the strobe
    exp_rd(REQ_HIST, HTREE_BASE, 1'b1, 4);
    start_req(REQ_HIST, 1'b0, HTREE_BASE, 0);
    run_until_idle(100);

    // four-beat write burst
    for (int b = 0; b < 4; b++) exp_wr(REQ_CODEBOOK, CODEBOOK_BASE + 32'(4 * b), wd(b), b == 3);
    start_req(REQ_CODEBOOK, 1'b1, CODEBOOK_BASE, 3);
    run_until_idle(200);

    // busy never rises: abort 15 cycles after strobe, then next requester
    sq.push_back('{we: 1'b0, id: 3'(REQ_TRN), addr: STUCK_ADDR, wdata: 32'd0});
    rq.push_back('{ack: '0, done: oh(REQ_TRN), err: 1'b1, rdata: last_rd, gap: 15});
    exp_rd(REQ_FLV, 32'h0000_0010, 1'b1, 4);
    start_req(REQ_TRN, 1'b0, STUCK_ADDR, 0);
    start_req(REQ_FLV, 1'b0, 32'h0000_0010, 0);
    run_until_idle(200);

    // reset in WAIT_DONE of beat 2, then the burst restarts from beat 0
    exp_rd(REQ_HTREE, 32'h0000_0200, 1'b0, 0);
    exp_rd(REQ_HTREE, 32'h0000_0204, 1'b0, 0);
    sq.push_back('{we: 1'b0, id: 3'(REQ_HTREE), addr: 32'h0000_0208, wdata: 32'd0});
    start_req(REQ_HTREE, 1'b0, 32'h0000_0200, 3);
    n    = 0;
    acks = 0;
    while (acks < 2 && n < 100) begin
      @(posedge clk);
      #1;
      if (bus.beat_ack[REQ_HTREE]) acks++;
      n++;
    end
    chk("reach_beat2", acks, 2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midburst_reset_outputs", outs(), '0);
    chk("midburst_strobes_used", sq.size(), 0);
    chk("midburst_resps_used", rq.size(), 0);
    for (int b = 0; b < 4; b++) exp_rd(REQ_HTREE, 32'h0000_0200 + 32'(4 * b), b == 3, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    run_until_idle(200);

    // address wrap across 2^32
    exp_rd(REQ_HIST, 32'hFFFF_FFFC, 1'b0, 0);
    exp_rd(REQ_HIST, 32'h0000_0000, 1'b1, 0);
    start_req(REQ_HIST, 1'b0, 32'hFFFF_FFFC, 1);
    run_until_idle(100);

    chk("idle_select", bus.select, 4'h0);
    chk("idle_busy", bus.arb_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
